// File: rtl/cycle_readback_pkg.sv
// cycle_readback_pkg: constants and types shared by the arbitrage-cycle
// readback slave and its FIFO.
//   - register addresses of the read-only Avalon map
//   - bit positions inside the DATA register
//   - FIFO entry layout {last, vtx} for the default vertex width
package cycle_readback_pkg;

  localparam int PRED_WIDTH = 7;
  localparam int VTX_WIDTH  = PRED_WIDTH + 1;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_INFO   = 3'd2;

  localparam int VALID_BIT = 31;
  localparam int LAST_BIT  = 30;

  // cycles_pending is an 8-bit saturating counter
  localparam logic [7:0] PEND_MAX = 8'hFF;

  // Entry layout; the FIFO itself stores it flattened as {last, vtx}.
  typedef struct packed {
    logic                 last;
    logic [VTX_WIDTH-1:0] vtx;
  } fifo_entry_t;

endpackage

// File: rtl/cycle_readback_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   push_i/wdata_i write strobe and data (ignored when full)
//   pop_i          read strobe (ignored when empty)
//   rdata_o        head entry, valid while !empty_o
//   full_o/empty_o/count_o  status from registered pointers only
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign count_o = wptr_q - rptr_q;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; only entries between the pointers are visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cycle_readback.sv
// cycle_readback: read-direction Avalon-MM slave returning detected arbitrage
// cycles to the HPS. The graph core streams vertex indices (with a last
// marker per cycle) into a FIFO; the HPS drains it through register reads.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_vtx/in_last/in_valid/in_ready producer stream (ready = !full)
//   chipselect/read/address          Avalon read request, 3-bit register select
//   readdata                         registered read data, latency 1, held
//   irq                              (cycles_pending != 0), only when the
//                                    REPORT_IRQ_EN macro is defined
// Registers: 0 STATUS, 1 DATA (pops one entry), 2 INFO, 3..7 read 0.
module cycle_readback
  import cycle_readback_pkg::*;
#(
  parameter int VTX_W = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VTX_W-1:0] in_vtx,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             chipselect,
  input  logic             read,
  input  logic [2:0]       address,
  output logic [31:0]      readdata
`ifdef REPORT_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [VTX_W:0] fifo_rdata;
  logic           fifo_full, fifo_empty;
  logic [AW:0]    fifo_count;
  logic           push, pop, rd_req, push_last, pop_last;
  logic [7:0]     pending_q, pending_d;
  logic [31:0]    readdata_q, readdata_d;

  // Ready comes only from registered state; a same-cycle pop never opens it.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign rd_req   = chipselect && read;
  assign pop      = rd_req && (address == REG_DATA) && !fifo_empty;

  sync_fifo #(.WIDTH(VTX_W+1), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({in_last, in_vtx}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign push_last = push && in_last;
  assign pop_last  = pop && fifo_rdata[VTX_W];

  // Simultaneous arrival and departure of a last entry cancel out.
  always_comb begin
    pending_d = pending_q;
    if (push_last && !pop_last && pending_q != PEND_MAX)
      pending_d = pending_q + 8'd1;
    else if (!push_last && pop_last && pending_q != 8'd0)
      pending_d = pending_q - 8'd1;
  end

  // Read data is captured on the same edge that performs the pop.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_req) begin
      readdata_d = '0;
      case (address)
        REG_STATUS: begin
          readdata_d[7:0]   = 8'(fifo_count);
          readdata_d[8]     = fifo_empty;
          readdata_d[9]     = fifo_full;
          readdata_d[23:16] = pending_q;
        end
        REG_DATA: begin
          if (!fifo_empty) begin
            readdata_d[VALID_BIT]   = 1'b1;
            readdata_d[LAST_BIT]    = fifo_rdata[VTX_W];
            readdata_d[VTX_W-1:0]   = fifo_rdata[VTX_W-1:0];
          end
        end
        REG_INFO: begin
          readdata_d[15:0]  = 16'(DEPTH);
          readdata_d[23:16] = 8'(VTX_W);
        end
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      readdata_q <= '0;
    end else begin
      pending_q  <= pending_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;

`ifdef REPORT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= (pending_d != 8'd0);
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_cycle_readback.sv
module tb_cycle_readback;

  localparam int VTX_W = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [VTX_W-1:0] in_vtx;
  logic             in_last, in_valid, in_ready;
  logic             chipselect, read;
  logic [2:0]       address;
  logic [31:0]      readdata;
`ifdef REPORT_IRQ_EN
  logic             irq;
`endif

  cycle_readback #(.VTX_W(VTX_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_vtx     (in_vtx),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .chipselect (chipselect),
    .read       (read),
    .address    (address),
    .readdata   (readdata)
`ifdef REPORT_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents as {last, vtx} and count of buffered lasts.
  logic [VTX_W:0] mq [$];
  int             pend;
  logic [31:0]    exp_q [$];
  logic           last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h t=%0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: begin
        r[7:0]   = 8'(mq.size());
        r[8]     = (mq.size() == 0);
        r[9]     = (mq.size() == DEPTH);
        r[23:16] = 8'((pend > 255) ? 255 : pend);
      end
      3'd1: if (mq.size() != 0) begin
        r[31]        = 1'b1;
        r[30]        = mq[0][VTX_W];
        r[VTX_W-1:0] = mq[0][VTX_W-1:0];
      end
      3'd2: begin
        r[15:0]  = 16'(DEPTH);
        r[23:16] = 8'(VTX_W);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Called at a falling edge; drives one cycle and advances the model.
  task automatic drive(input logic v, input logic [VTX_W-1:0] vx, input logic l,
                       input logic cs, input logic rd, input logic [2:0] a);
    logic acc, popped;
    logic [VTX_W:0] e;
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
`ifdef REPORT_IRQ_EN
    chk("irq", {31'd0, irq}, {31'd0, pend != 0});
`endif
    in_valid = v; in_vtx = vx; in_last = l;
    chipselect = cs; read = rd; address = a;
    acc    = v && (mq.size() < DEPTH);
    popped = cs && rd && (a == 3'd1) && (mq.size() != 0);
    if (cs && rd) exp_q.push_back(model_read(a));
    if (popped) begin
      e = mq.pop_front();
      if (e[VTX_W]) pend--;
    end
    if (acc) begin
      mq.push_back({l, vx});
      if (l) pend++;
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, a);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_vtx = '0; in_last = 1'b0;
    chipselect = 1'b0; read = 1'b0; address = '0;
    @(negedge clk);
    mq.delete(); pend = 0; exp_q.delete();
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef REPORT_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
    reset = 1'b0;
  endtask

  // Monitor: each non-reset cycle, readdata must equal the newest expected
  // read response, held until the next read.
  logic [31:0] last_exp = '0;
  logic        mon_rd, mon_rs;
  always @(posedge clk) begin
    mon_rs = reset;
    mon_rd = chipselect && read;
    #1;
    if (mon_rs) last_exp = '0;
    else begin
      if (mon_rd) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_underflow t=%0t", $time);
        end else last_exp = exp_q.pop_front();
      end
      chk("readdata", readdata, last_exp);
    end
  end

  logic             pv, pl;
  logic [VTX_W-1:0] pvx;
  logic             rcs, rrd;
  logic [2:0]       ra;

  initial begin
    pend = 0;
    do_reset();

    // Empty-state register reads
    rd_reg(3'd0); rd_reg(3'd2); rd_reg(3'd5); rd_reg(3'd1); rd_reg(3'd0);

    // Short cycle 5,9,2(last)
    drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 3'd0);
    rd_reg(3'd0);
    rd_reg(3'd1); rd_reg(3'd1); rd_reg(3'd1);
    rd_reg(3'd0);

    // Fill to DEPTH, then hold a 17th beat until one pop frees a slot
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 8'(i + 20), (i % 5) == 4, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'd99, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("full_hold_not_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'd99, 1'b1, 1'b0, 1'b0, 3'd0);
    drive(1'b1, 8'd99, 1'b1, 1'b1, 1'b1, 3'd1);
    drive(1'b1, 8'd99, 1'b1, 1'b0, 1'b0, 3'd0);
    chk("held_beat_accepted", {31'd0, last_acc}, 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
    rd_reg(3'd0);
    for (int i = 0; i < DEPTH; i++) rd_reg(3'd1);
    rd_reg(3'd0);

    // Empty with push and DATA read in the same cycle
    drive(1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 3'd1);
    // Last pushed while a last is popped: pending and occupancy unchanged
    drive(1'b1, 8'd8, 1'b1, 1'b1, 1'b1, 3'd1);
    rd_reg(3'd0);
    rd_reg(3'd1);
    rd_reg(3'd0);

    // Reset with entries buffered
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(40 + i), i == 3, 1'b0, 1'b0, 3'd0);
    do_reset();
    rd_reg(3'd0);
    rd_reg(3'd1);

    // Random traffic: producer-heavy phase, then reader-heavy phase
    pv = 1'b0; pvx = '0; pl = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!pv && $urandom_range(0, 99) < ((c < 300) ? 80 : 35)) begin
        pv  = 1'b1;
        pvx = 8'($urandom);
        pl  = ($urandom_range(0, 3) == 0);
      end
      rcs = ($urandom_range(0, 99) < ((c < 300) ? 35 : 75));
      rrd = ($urandom_range(0, 4) != 0);
      ra  = ($urandom_range(0, 3) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
      drive(pv, pvx, pl, rcs, rrd, ra);
      if (last_acc) pv = 1'b0;
    end

    // Drain whatever remains
    for (int i = 0; i < DEPTH + 2; i++) rd_reg(3'd1);
    rd_reg(3'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
